// File: rtl/compare_arbiter.sv
// Round-robin arbiter that time-shares one unsigned magnitude comparator among
// NREQ requesters: IDLE grants and captures operands, CMP registers the result, DONE releases.
module compare_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic                    done,
    output logic                    lt,
    output logic                    eq,
    output logic                    gt
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    opnd_t      opnd;

    // First requester at or above ptr, wrapping; 2-bit add gives the 3 -> 0 wrap for free.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            done  <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            opnd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        opnd.a <= a_in[win*WIDTH +: WIDTH];
                        opnd.b <= b_in[win*WIDTH +: WIDTH];
                        owner  <= win;
                        gnt    <= NREQ'(1) << win;
                    end
                end
                CMP: begin
                    lt   <= (opnd.a <  opnd.b);
                    eq   <= (opnd.a == opnd.b);
                    gt   <= (opnd.a >  opnd.b);
                    done <= 1'b1;
                end
                DONE: begin
                    // Rotate priority past the requester just served.
                    done <= 1'b0;
                    gnt  <= '0;
                    ptr  <= owner + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: reset state, single and contending requests,
// rotation, comparator sweep, reset abort and operand isolation after capture.
module tb_compare_arbiter;
    localparam int WIDTH = 3;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic                  busy;
    logic                  done;
    logic                  lt;
    logic                  eq;
    logic                  gt;

    int n_tests = 0;
    int n_fail  = 0;

    compare_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: set requester own's operands, raise r, check the 3-edge sequence.
    task automatic run_op(input logic [3:0] r, input int own, input int ea, input int eb);
        logic [3:0] exp_gnt;
        logic [2:0] exp_cmp;
        a_in[own*WIDTH +: WIDTH] = WIDTH'(ea);
        b_in[own*WIDTH +: WIDTH] = WIDTH'(eb);
        req     = r;
        exp_gnt = 4'b0001 << own;
        if (ea < eb)       exp_cmp = 3'b100;
        else if (ea == eb) exp_cmp = 3'b010;
        else               exp_cmp = 3'b001;
        step();
        chk("op_gnt", 32'(gnt), 32'(exp_gnt));
        chk("op_busy1", 32'(busy), 32'd1);
        chk("op_done0", 32'(done), 32'd0);
        step();
        chk("op_done", 32'(done), 32'd1);
        chk("op_owner", 32'(owner), 32'(own));
        chk("op_cmp", 32'({lt, eq, gt}), 32'(exp_cmp));
        step();
        chk("op_idle_busy", 32'(busy), 32'd0);
        chk("op_idle_done", 32'(done), 32'd0);
        chk("op_idle_gnt", 32'(gnt), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmp", 32'({lt, eq, gt}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // No request: block stays idle.
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Single requester 0, 3 vs 5.
        run_op(4'b0001, 0, 3, 5);
        req = '0;

        // All requesting after reset: 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run_op(4'b1111, i % 4, i % 4, 2);
        req = '0;

        // ptr is now 1: serve requester 1, then 0110 -> 2 then 1.
        run_op(4'b0010, 1, 4, 4);
        run_op(4'b0110, 2, 6, 1);
        run_op(4'b0110, 1, 0, 7);
        req = '0;

        // Requester 3 directed pairs then exhaustive sweep.
        run_op(4'b1000, 3, 7, 7);
        run_op(4'b1000, 3, 0, 7);
        run_op(4'b1000, 3, 7, 0);
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                run_op(4'b1000, 3, a, b);
        req = '0;

        // Reset during CMP aborts with no done; ptr returns to 0.
        a_in[2*WIDTH +: WIDTH] = 3'd5;
        req = 4'b0100;
        step();
        chk("abort_gnt_pre", 32'(gnt), 32'b0100);
        rst = 1'b1;
        req = '0;
        step();
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_cmp", 32'({lt, eq, gt}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run_op(4'b1000, 3, 1, 1);
        req = '0;

        // Owner drops req and changes operands during CMP: result uses captured 2 vs 6.
        a_in[0 +: WIDTH] = 3'd2;
        b_in[0 +: WIDTH] = 3'd6;
        req = 4'b0001;
        step();
        chk("iso_gnt", 32'(gnt), 32'b0001);
        req = '0;
        a_in[0 +: WIDTH] = 3'd7;
        b_in[0 +: WIDTH] = 3'd1;
        step();
        chk("iso_done", 32'(done), 32'd1);
        chk("iso_cmp", 32'({lt, eq, gt}), 32'b100);
        step();
        step();
        chk("hold_cmp", 32'({lt, eq, gt}), 32'b100);
        chk("hold_owner", 32'(owner), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/compare_arbiter.md
COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001 Parameter: WIDTH, 3, operand width in bits.
REQ-002 Parameter: NREQ, 4, number of requesters (fixed at 4; owner is 2 bits).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req  input  NREQ  per-requester compare request, level.
REQ-006 Port: a_in  input  NREQ*WIDTH  operand A per requester; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 Port: b_in  input  NREQ*WIDTH  operand B per requester; same packing as a_in.
REQ-008 Port: gnt  output  NREQ  one-hot grant, registered.
REQ-009 Port: owner  output  2  index of the requester currently or last granted, registered.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: done  output  1  one-cycle result-valid pulse, registered.
REQ-012 Port: lt, eq, gt  output  1 each  unsigned A<B, A==B, A>B of the owner's operands, registered.

Function
REQ-013 The block SHALL time-share one unsigned WIDTH-bit magnitude comparator among NREQ requesters.
REQ-014 FSM states SHALL be IDLE, CMP, DONE; no other state is reachable.
REQ-015 IDLE: if any req bit is high at a clock edge, the block SHALL select the winner round-robin, starting at pointer ptr and searching upward with wrap (3 -> 0).
REQ-016 On that edge it SHALL register the winner's a_in/b_in slices into internal operand registers, set owner to the winner, set gnt to onehot(winner), and go to CMP.
REQ-017 IDLE with req == 0 SHALL hold all state; gnt stays 0.
REQ-018 CMP: on the next edge it SHALL register lt/eq/gt from the captured operands, set done = 1, and go to DONE.
REQ-019 DONE: on the next edge it SHALL clear done and gnt, set ptr = owner + 1 (mod 4), and go to IDLE.
REQ-020 Latency: req sampled at edge k gives gnt after edge k, done after edge k+1, and IDLE after edge k+2; maximum throughput is one compare per 3 cycles.
REQ-021 Exactly one of lt/eq/gt SHALL be high after the first completed compare.
REQ-022 lt/eq/gt and owner SHALL hold their values from done until the next done.
REQ-023 Operands SHALL be captured only in IDLE; a_in/b_in changes in CMP or DONE SHALL NOT affect the result.
REQ-024 A req deasserted during CMP or DONE SHALL NOT abort the operation; done is still issued for the owner.
REQ-025 A requester holding req high through DONE SHALL compete again in the next IDLE at rotated priority; it gets no back-to-back win if another req is pending.
REQ-026 Simultaneous requests SHALL yield exactly one grant; other requests wait, with no loss and no starvation (wait of at most 3 operations).
REQ-027 busy SHALL be decoded from the registered state only.

Reset
REQ-028 With rst high at an edge: state = IDLE, ptr = 0, owner = 0, gnt = 0, done = 0, lt = eq = gt = 0, operand registers = 0.
REQ-029 Reset SHALL take priority over all transitions; rst during CMP or DONE aborts the operation with no done pulse.
REQ-030 The first request evaluated after reset SHALL use ptr = 0.

Verification
REQ-031 Reset, then req = 0001, a0 = 3, b0 = 5 -> gnt = 0001 after 1 edge; done = 1, lt = 1, eq = 0, gt = 0, owner = 0 after 2 edges; busy = 0 after 3 edges.
REQ-032 After reset, req = 1111 held -> owners served 0, 1, 2, 3, 0; done every 3 cycles; gnt always one-hot or zero.
REQ-033 Requester 1 served, then req = 0110 -> requester 2 wins (ptr = 2); requester 1 follows.
REQ-034 Requester 3 with pairs (7,7), (0,7), (7,0) -> eq, lt, gt respectively; exhaustive 64-pair sweep matches a reference model.
REQ-035 rst pulsed during CMP -> no done; all outputs 0 after that edge; next req = 1000 is served with owner = 3.
REQ-036 Owner drops req and changes a_in during CMP -> done still pulses, result reflects the operands captured in IDLE.
